acq_hold_sym: RTL and testbench
===============================

# acq_hold_sym

Parametrised serial-bit acquisition and symbol hold stage for the configurable modulator. Samples a slow asynchronous serial bit stream at mid-bit, realigns its bit phase on every input transition, and assembles 1 to SYM_W bits into a symbol. The symbol is held on `out` until the next symbol is complete. It feeds the modulator's symbol mapper and generalises the fixed 2-bit acquisition stage to a run-time selectable bits-per-symbol mode.

## Interface
- `CLKS_PER_BIT`, default 25000: clk cycles per serial bit (50 MHz / 2 kHz); must be ≥ 4.
- `SYM_W`, default 4: width of `out`; the maximum bits per symbol.
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: reset, synchronous and active-low.
- `in` input, 1 bit: asynchronous serial data bit.
- `en` input, 1 bit: acquisition enable.
- `mode` input, 2 bits: bits per symbol = `mode`+1, clamped to SYM_W.
- `out` output, SYM_W bits: held symbol, right-justified, upper bits zero.
- `sym_valid` output, 1 bit: one-cycle pulse when `out` updates.
- `bit_tick` output, 1 bit: one-cycle pulse in each cycle a bit is sampled.

## Operation
- Input path: `in` passes through a 2-flop synchroniser to give `in_s`, then one more flop gives `in_d`. `edge` = `in_s` ≠ `in_d`.
- Phase counter: width $clog2(CLKS_PER_BIT).
  - Reset to 0 on `edge`.
  - Otherwise increments and wraps from CLKS_PER_BIT−1 to 0.
- HALF = CLKS_PER_BIT/2, integer division.
- FSM states: IDLE and RUN.
  - IDLE: phase counter held at 0; shift register and bit count cleared; `out` retains its value. Goes to RUN on the first `edge` while `en`=1, and that cycle sets phase to 0.
  - RUN: a sample is taken in the cycle where phase == HALF and `edge`=0. In that cycle `bit_tick`=1, `in_s` shifts into the shift register at the LSB (first received bit ends up as the MSB of the symbol), and the bit count increments.
  - When bit count reaches NB = latched bits per symbol: the symbol is transferred to `out`, `sym_valid` pulses, bit count returns to 0 and `mode` is re-latched.
  - `en`=0 in any state: IDLE on the next clock. A partial symbol is discarded.
- Mode latching:
  - `mode` is sampled into `mode_q` only in IDLE or on a symbol-complete cycle.
  - A mid-symbol change of `mode` has no effect until the next boundary.
  - NB = min(`mode_q`+1, SYM_W).
- Edge and sample in the same cycle: the edge wins, phase resets and no sample is taken.
- Long runs without transitions: the free-running wrap continues to give one sample per CLKS_PER_BIT cycles.

## Timing
- Reset (`rst`=0 at a clk edge): state=IDLE, `out`=0, `sym_valid`=0, `bit_tick`=0, phase=0, bit count=0, shift register=0, `mode_q`=`mode`, synchroniser flops=0.
- Latency from a change on `in` to `edge`: 3 clk (2 synchroniser stages plus 1 detect).
- Edge to first `bit_tick`: HALF clk.
- Consecutive `bit_tick` pulses without resync: CLKS_PER_BIT clk apart.
- Last `bit_tick` of a symbol to `out`/`sym_valid`: 1 clk.
- `out` is stable between `sym_valid` pulses.
- `sym_valid` and `bit_tick` are never high in the same cycle.
- Release of reset mid-stream: the block waits in IDLE for an edge and never emits a partial symbol.

## Configuration
- Macro `ACQ_HOLD_GRAY_EN`.
  - Defined: the completed symbol is binary-to-Gray converted (sym ^ (sym>>1), over NB bits) before loading `out`, so adjacent constellation points differ by one bit.
  - Undefined: `out` is loaded with the raw shifted bits.
  - Timing and all other behaviour are identical in both builds.

## Test plan
All scenarios use CLKS_PER_BIT=8, SYM_W=4.
1. Reset and enable: hold `rst`=0 for 2 clk with `in` toggling, then release with `en`=1, `mode`=1 → `out`=0 and no pulses during reset. First `bit_tick` occurs 3+4 clk after the first `in` toggle.
2. QPSK: `mode`=1, bits 1,0,1,1 at 8 clk/bit → `sym_valid` twice, `out`=2'b10 then 2'b11, each 1 clk after the second `bit_tick` of its symbol. With `ACQ_HOLD_GRAY_EN` defined: 2'b11 then 2'b10.
3. Mode change mid-symbol: `mode`=3, change `mode` to 0 after 2 bits of 1,1,0,1 → `out`=4'b1101. The following bits then each produce a 1-bit symbol.
4. Jitter resync: shift an `in` transition 2 clk late → phase resets on `edge` and the next `bit_tick` comes HALF clk after it. No bit is lost or duplicated over a 16-bit PRBS stream; compare against a reference model.
5. Abort: deassert `en` after 1 bit of a 4-bit symbol → no `sym_valid`, `out` unchanged. After re-enable and an edge, the next full symbol is correct.
6. Clamp and hold: `mode`=3 with SYM_W=2 → NB=2. A long run of 0s gives `bit_tick` every 8 clk and `out`=2'b00.

Source files
------------

// File: rtl/acq_hold_sym.sv
// acq_hold_sym: mid-bit sampler for a slow async serial line, with phase resync on every
// transition and a 1..SYM_W bit symbol hold. Define ACQ_HOLD_GRAY_EN to Gray-code symbols.
module acq_hold_sym #(
    parameter int unsigned CLKS_PER_BIT = 25000,
    parameter int unsigned SYM_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [SYM_W-1:0] out,
    output logic             sym_valid,
    output logic             bit_tick
);

    localparam int unsigned   PW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned   CW   = $clog2(SYM_W + 1);
    localparam logic [PW-1:0] HALF = PW'(CLKS_PER_BIT / 2);
    localparam logic [PW-1:0] LAST = PW'(CLKS_PER_BIT - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state;
    logic             in_meta, in_s, in_d, in_edge;
    logic [PW-1:0]    phase;
    logic [CW-1:0]    bit_cnt;
    logic [SYM_W-1:0] shreg;
    logic [1:0]       mode_q;
    logic [CW-1:0]    nb;
    logic [SYM_W-1:0] shreg_nxt;
    logic [SYM_W-1:0] sym_nxt;
    logic             sample;
    logic             sym_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            in_meta <= 1'b0;
            in_s    <= 1'b0;
            in_d    <= 1'b0;
        end else begin
            in_meta <= in;
            in_s    <= in_meta;
            in_d    <= in_s;
        end
    end

    assign in_edge = in_s ^ in_d;

    always_comb begin
        int unsigned req;
        req = int'(mode_q) + 1;
        nb  = (req > SYM_W) ? CW'(SYM_W) : CW'(req);
    end

    // A transition in the same cycle as the mid-bit point wins: resync, no sample.
    assign sample    = (state == StRun) && en && (phase == HALF) && !in_edge;
    assign bit_tick  = sample && rst;
    assign sym_done  = sample && ((bit_cnt + CW'(1)) == nb);
    assign shreg_nxt = (shreg << 1) | SYM_W'(in_s);

    // Shift register is cleared at every boundary, so bits above NB are already zero.
`ifdef ACQ_HOLD_GRAY_EN
    assign sym_nxt = shreg_nxt ^ (shreg_nxt >> 1);
`else
    assign sym_nxt = shreg_nxt;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= StIdle;
            phase     <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            mode_q    <= mode;
            out       <= '0;
            sym_valid <= 1'b0;
        end else begin
            sym_valid <= 1'b0;
            if (!en || state == StIdle) begin
                phase   <= '0;
                bit_cnt <= '0;
                shreg   <= '0;
                if (state == StIdle) begin
                    mode_q <= mode;
                end
                state <= (en && in_edge) ? StRun : StIdle;
            end else begin
                if (in_edge || phase == LAST) begin
                    phase <= '0;
                end else begin
                    phase <= phase + PW'(1);
                end
                if (sym_done) begin
                    out       <= sym_nxt;
                    sym_valid <= 1'b1;
                    bit_cnt   <= '0;
                    shreg     <= '0;
                    mode_q    <= mode;
                end else if (sample) begin
                    shreg   <= shreg_nxt;
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_acq_hold_sym.sv
// Randomised bench for acq_hold_sym: transition-time timing model plus bit-grouping symbol model.
module tb_acq_hold_sym;

    localparam int CLKS = 8;
    localparam int HALF = CLKS / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [3:0] dout;
    logic       sv, tk;
    logic [1:0] dout2;
    logic       sv2, tk2;

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    int         tk1[$], sv1_c[$];
    logic [3:0] sv1_v[$];
    int         tk2q[$], sv2_c[$];
    logic [1:0] sv2_v[$];

    bit         st_bits[$];
    int         st_dur[$];
    int         tr_c[$];
    int         en_off;
    int         mchg_cyc;
    int         ex_tk[$], ex_sc[$];
    logic [3:0] ex_sv[$];
    logic [3:0] out_prev = 4'd0;
    logic [1:0] out2_prev = 2'd0;

    acq_hold_sym #(.CLKS_PER_BIT(CLKS), .SYM_W(4)) dut (
        .clk(clk), .rst(rst), .in(din), .en(en), .mode(mode),
        .out(dout), .sym_valid(sv), .bit_tick(tk)
    );

    acq_hold_sym #(.CLKS_PER_BIT(CLKS), .SYM_W(2)) dut2 (
        .clk(clk), .rst(rst), .in(din), .en(en), .mode(mode),
        .out(dout2), .sym_valid(sv2), .bit_tick(tk2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tk) tk1.push_back(cyc);
        if (sv) begin sv1_c.push_back(cyc); sv1_v.push_back(dout); end
        if (tk2) tk2q.push_back(cyc);
        if (sv2) begin sv2_c.push_back(cyc); sv2_v.push_back(dout2); end
        if (rst) begin
            n_cmp++;
            if ((sv && tk) || (sv2 && tk2)) begin
                n_fail++;
                $display("FAIL tick_valid_overlap: cycle %0d got both high want exclusive", cyc);
            end
            n_cmp++;
            if ((dout !== out_prev && !sv) || (dout2 !== out2_prev && !sv2)) begin
                n_fail++;
                $display("FAIL out_hold: cycle %0d got %h/%h want %h/%h", cyc, dout, dout2,
                         out_prev, out2_prev);
            end
        end
        out_prev  = dout;
        out2_prev = dout2;
    end

    task automatic clear_mon();
        tk1.delete(); sv1_c.delete(); sv1_v.delete();
        tk2q.delete(); sv2_c.delete(); sv2_v.delete();
    endtask

    // Drives st_bits/st_dur starting from the opposite idle level, then drops en.
    task automatic run_stream(input int m0, input int chg_idx, input int m1);
        bit lvl;
        @(posedge clk);
        #1;
        en = 1'b0; din = ~st_bits[0]; mode = m0[1:0];
        repeat (5) @(posedge clk);
        #1 en = 1'b1;
        repeat (4) @(posedge clk);
        clear_mon();
        tr_c.delete();
        mchg_cyc = -1;
        lvl = ~st_bits[0];
        for (int i = 0; i < st_bits.size(); i++) begin
            #1;
            if (i == chg_idx) begin mode = m1[1:0]; mchg_cyc = cyc; end
            if (st_bits[i] != lvl) tr_c.push_back(cyc);
            din = st_bits[i];
            lvl = st_bits[i];
            repeat (st_dur[i]) @(posedge clk);
        end
        repeat (2) @(posedge clk);
        #1 en = 1'b0;
        en_off = cyc;
        repeat (6) @(posedge clk);
    endtask

    // Ticks: HALF after phase restarts (3 clk after a line change), then every CLKS until the
    // next detected change or the loss of enable. Symbols: sent bits grouped MSB-first.
    task automatic build_expected(input int symw, input int m0, input int m1);
        int i, nb, mcur, c, lim, v;
        ex_tk.delete(); ex_sc.delete(); ex_sv.delete();
        for (int j = 0; j < tr_c.size(); j++) begin
            lim = (j + 1 < tr_c.size()) ? tr_c[j+1] + 2 : en_off;
            for (c = tr_c[j] + 3 + HALF; c < lim; c += CLKS) ex_tk.push_back(c);
        end
        i = 0;
        mcur = m0;
        while (1) begin
            nb = (mcur + 1 > symw) ? symw : mcur + 1;
            if (i + nb > ex_tk.size() || i + nb > st_bits.size()) break;
            v = 0;
            for (int k = 0; k < nb; k++) v = (v << 1) | int'(st_bits[i+k]);
`ifdef ACQ_HOLD_GRAY_EN
            v = v ^ (v >> 1);
`endif
            c = ex_tk[i+nb-1];
            ex_sc.push_back(c + 1);
            ex_sv.push_back(v[3:0]);
            mcur = (mchg_cyc >= 0 && c >= mchg_cyc) ? m1 : m0;
            i += nb;
        end
    endtask

    task automatic test_reset();
        int t;
        rst = 1'b0; en = 1'b1; mode = 2'd1;
        repeat (2) begin @(posedge clk); #1 din = ~din; end
        @(negedge clk);
        n_cmp++;
        if (dout !== 4'd0 || sv !== 1'b0 || tk !== 1'b0 || dout2 !== 2'd0 || sv2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got out=%h sv=%b tk=%b out2=%h want 0", dout, sv, tk,
                     dout2);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        clear_mon();
        repeat (4) @(posedge clk);
        #1 din = 1'b1;
        t = cyc;
        repeat (12) @(posedge clk);
        #1 en = 1'b0;
        repeat (4) @(posedge clk);
        n_cmp++;
        if (tk1.size() !== 1) begin
            n_fail++;
            $display("FAIL reset_first_tick_count: got %0d want 1", tk1.size());
        end else begin
            n_cmp++;
            if (tk1[0] !== t + 7) begin
                n_fail++;
                $display("FAIL reset_first_tick_cycle: got %0d want %0d", tk1[0], t + 7);
            end
        end
        n_cmp++;
        if (sv1_c.size() !== 0 || dout !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_no_symbol: got %0d symbols out=%h want 0 symbols out=0",
                     sv1_c.size(), dout);
        end
    endtask

    task automatic test_qpsk();
        st_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
        st_dur  = '{CLKS, CLKS, CLKS, CLKS};
        run_stream(1, -1, 1);
        build_expected(4, 1, 1);
        n_cmp++;
        if (tk1.size() !== 4) begin
            n_fail++; $display("FAIL qpsk_tick_count: got %0d want 4", tk1.size());
        end
        for (int i = 0; i < ex_tk.size(); i++) begin
            n_cmp++;
            if (i >= tk1.size() || tk1[i] !== ex_tk[i]) begin
                n_fail++;
                $display("FAIL qpsk_tick[%0d]: got %0d want %0d", i,
                         (i < tk1.size()) ? tk1[i] : -1, ex_tk[i]);
            end
        end
        n_cmp++;
        if (sv1_c.size() !== 2) begin
            n_fail++; $display("FAIL qpsk_sym_count: got %0d want 2", sv1_c.size());
        end
        for (int i = 0; i < ex_sc.size() && i < sv1_c.size(); i++) begin
            n_cmp++;
            if (sv1_c[i] !== ex_sc[i] || sv1_v[i] !== ex_sv[i]) begin
                n_fail++;
                $display("FAIL qpsk_sym[%0d]: got cyc %0d val %h want cyc %0d val %h", i,
                         sv1_c[i], sv1_v[i], ex_sc[i], ex_sv[i]);
            end
        end
        if (sv1_v.size() == 2) begin
            n_cmp++;
`ifdef ACQ_HOLD_GRAY_EN
            if (sv1_v[0] !== 4'b0011 || sv1_v[1] !== 4'b0010) begin
`else
            if (sv1_v[0] !== 4'b0010 || sv1_v[1] !== 4'b0011) begin
`endif
                n_fail++;
                $display("FAIL qpsk_values: got %b %b", sv1_v[0], sv1_v[1]);
            end
        end
    endtask

    task automatic test_mode_change();
        st_bits = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        st_dur  = '{CLKS, CLKS, CLKS, CLKS, CLKS, CLKS, CLKS};
        run_stream(3, 2, 0);
        build_expected(4, 3, 0);
        n_cmp++;
        if (sv1_c.size() !== 4 || ex_sc.size() !== 4) begin
            n_fail++;
            $display("FAIL modechg_sym_count: got %0d want 4", sv1_c.size());
        end
        for (int i = 0; i < ex_sc.size() && i < sv1_c.size(); i++) begin
            n_cmp++;
            if (sv1_c[i] !== ex_sc[i] || sv1_v[i] !== ex_sv[i]) begin
                n_fail++;
                $display("FAIL modechg_sym[%0d]: got cyc %0d val %h want cyc %0d val %h", i,
                         sv1_c[i], sv1_v[i], ex_sc[i], ex_sv[i]);
            end
        end
        if (sv1_v.size() > 0) begin
            n_cmp++;
`ifdef ACQ_HOLD_GRAY_EN
            if (sv1_v[0] !== 4'b1011) begin
`else
            if (sv1_v[0] !== 4'b1101) begin
`endif
                n_fail++;
                $display("FAIL modechg_first_symbol: got %b", sv1_v[0]);
            end
        end
    endtask

    task automatic test_jitter(input int iter);
        int j, m;
        st_bits.delete(); st_dur.delete();
        for (int i = 0; i < 16; i++) begin
            st_bits.push_back(bit'($urandom_range(1, 0)));
            st_dur.push_back(CLKS);
        end
        j = $urandom_range(12, 2);
        st_bits[j+1] = ~st_bits[j];
        st_dur[j]    = CLKS + 2;
        st_dur[j+1]  = CLKS - 2;
        m = $urandom_range(3, 0);
        run_stream(m, -1, m);
        build_expected(4, m, m);
        n_cmp++;
        if (tk1.size() !== 16) begin
            n_fail++;
            $display("FAIL jitter%0d_tick_count: got %0d want 16", iter, tk1.size());
        end
        for (int i = 0; i < ex_tk.size(); i++) begin
            n_cmp++;
            if (i >= tk1.size() || tk1[i] !== ex_tk[i]) begin
                n_fail++;
                $display("FAIL jitter%0d_tick[%0d]: got %0d want %0d", iter, i,
                         (i < tk1.size()) ? tk1[i] : -1, ex_tk[i]);
            end
        end
        n_cmp++;
        if (sv1_c.size() !== ex_sc.size()) begin
            n_fail++;
            $display("FAIL jitter%0d_sym_count: got %0d want %0d", iter, sv1_c.size(),
                     ex_sc.size());
        end
        for (int i = 0; i < ex_sc.size() && i < sv1_c.size(); i++) begin
            n_cmp++;
            if (sv1_c[i] !== ex_sc[i] || sv1_v[i] !== ex_sv[i]) begin
                n_fail++;
                $display("FAIL jitter%0d_sym[%0d]: got cyc %0d val %h want cyc %0d val %h",
                         iter, i, sv1_c[i], sv1_v[i], ex_sc[i], ex_sv[i]);
            end
        end
    endtask

    task automatic test_abort();
        logic [3:0] prev;
        prev = dout;
        st_bits = '{1'b1};
        st_dur  = '{CLKS};
        run_stream(3, -1, 3);
        n_cmp++;
        if (tk1.size() !== 1 || sv1_c.size() !== 0 || dout !== prev) begin
            n_fail++;
            $display("FAIL abort_partial: got ticks=%0d syms=%0d out=%h want 1 0 %h",
                     tk1.size(), sv1_c.size(), dout, prev);
        end
        st_bits.delete(); st_dur.delete();
        for (int i = 0; i < 4; i++) begin
            st_bits.push_back(bit'($urandom_range(1, 0)));
            st_dur.push_back(CLKS);
        end
        run_stream(3, -1, 3);
        build_expected(4, 3, 3);
        n_cmp++;
        if (sv1_c.size() !== 1 || ex_sc.size() !== 1) begin
            n_fail++; $display("FAIL abort_resume_count: got %0d want 1", sv1_c.size());
        end else begin
            n_cmp++;
            if (sv1_c[0] !== ex_sc[0] || sv1_v[0] !== ex_sv[0] || dout !== ex_sv[0]) begin
                n_fail++;
                $display("FAIL abort_resume_sym: got cyc %0d val %h want cyc %0d val %h",
                         sv1_c[0], sv1_v[0], ex_sc[0], ex_sv[0]);
            end
        end
    endtask

    task automatic test_clamp();
        st_bits.delete(); st_dur.delete();
        for (int i = 0; i < 6; i++) begin st_bits.push_back(1'b0); st_dur.push_back(CLKS); end
        run_stream(3, -1, 3);
        build_expected(2, 3, 3);
        n_cmp++;
        if (tk2q.size() !== 6) begin
            n_fail++; $display("FAIL clamp_tick_count: got %0d want 6", tk2q.size());
        end
        for (int i = 0; i + 1 < tk2q.size(); i++) begin
            n_cmp++;
            if (tk2q[i+1] - tk2q[i] !== CLKS) begin
                n_fail++;
                $display("FAIL clamp_tick_spacing[%0d]: got %0d want %0d", i,
                         tk2q[i+1] - tk2q[i], CLKS);
            end
        end
        n_cmp++;
        if (sv2_c.size() !== 3 || ex_sc.size() !== 3) begin
            n_fail++; $display("FAIL clamp_sym_count: got %0d want 3", sv2_c.size());
        end
        for (int i = 0; i < ex_sc.size() && i < sv2_c.size(); i++) begin
            n_cmp++;
            if (sv2_c[i] !== ex_sc[i] || sv2_v[i] !== ex_sv[i][1:0]) begin
                n_fail++;
                $display("FAIL clamp_sym[%0d]: got cyc %0d val %h want cyc %0d val %h", i,
                         sv2_c[i], sv2_v[i], ex_sc[i], ex_sv[i][1:0]);
            end
        end
        n_cmp++;
        if (dout2 !== 2'b00) begin
            n_fail++; $display("FAIL clamp_out: got %b want 00", dout2);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_qpsk();
        test_mode_change();
        for (int it = 0; it < 3; it++) test_jitter(it);
        test_abort();
        test_clamp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
